// File: rtl/shared_timer_arbiter.sv
// Round-robin sharing of one down-counting interval timer between NREQ requesters.
// Optional SHARED_TIMER_STATS_EN adds a saturating done_total counter output.
module shared_timer_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] len_in,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      count,
   output logic                  busy
`ifdef SHARED_TIMER_STATS_EN
   ,
   output logic [7:0]            done_total
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     win_q, win_d;
   logic [PW:0]       arb;
   logic [PW-1:0]     win_nxt;
   logic [WIDTH-1:0]  arb_len;

   // Returns {found, index}; lower offsets from p overwrite higher ones, so the first hit wins.
   function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
      logic [PW:0] j;
      logic [PW:0] res;
      res = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = {1'b0, p} + (PW+1)'(i);
         if (j >= (PW+1)'(NREQ)) j = j - (PW+1)'(NREQ);
         if (r[j[PW-1:0]]) res = {1'b1, j[PW-1:0]};
      end
      return res;
   endfunction

   assign arb     = rr_pick(req, ptr_q);
   assign arb_len = len_in[arb[PW-1:0]*WIDTH +: WIDTH];
   assign win_nxt = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      unique case (state_q)
         IDLE: begin
            if (arb[PW]) begin
               win_d   = arb[PW-1:0];
               gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << arb[PW-1:0];
               cnt_d   = arb_len;
               state_d = (arb_len == '0) ? DONE : COUNT;
            end
         end
         COUNT: begin
            // Dropping the request abandons the interval silently; the winner still loses priority.
            if (!req[win_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
               ptr_d   = win_nxt;
            end else if (cnt_q <= WIDTH'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
            ptr_d   = win_nxt;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      gnt   = gnt_q;
      count = cnt_q;
      busy  = (state_q != IDLE);
      done  = (state_q == DONE) ? gnt_q : '0;
   end

`ifdef SHARED_TIMER_STATS_EN
   logic [7:0] tot_q, tot_d;

   always_comb begin
      tot_d = tot_q;
      if (state_q == DONE && tot_q != 8'hFF) tot_d = tot_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) tot_q <= '0;
      else       tot_q <= tot_d;
   end

   assign done_total = tot_q;
`endif

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Scoreboard bench for shared_timer_arbiter: timed state expectations plus a done-pulse queue.
module tb_shared_timer_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] len_in;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [3:0]  count;
   logic        busy;
`ifdef SHARED_TIMER_STATS_EN
   logic [7:0]  done_total;
`endif

   shared_timer_arbiter #(.WIDTH(4), .NREQ(4)) dut (
      .clock(clock), .reset(reset), .req(req), .len_in(len_in),
      .gnt(gnt), .done(done), .count(count), .busy(busy)
`ifdef SHARED_TIMER_STATS_EN
      , .done_total(done_total)
`endif
   );

   typedef struct {
      int         at;
      logic [3:0] gnt;
      logic [3:0] cnt;
      logic [3:0] dn;
      logic       busy;
      int         tot;
   } exp_t;

   typedef struct {
      int         at;
      logic [3:0] vec;
   } done_t;

   exp_t  exp_q[$];
   done_t done_q[$];
   int    edge_n = 0;
   int    n_cmp = 0;
   int    n_err = 0;
   bit    fin = 0;
   bit    mon_done = 0;

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) edge_n <= edge_n + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end

   task automatic exp_state(input int at, input logic [3:0] g, input logic [3:0] c,
                            input logic [3:0] d, input logic b, input int tot);
      exp_t e;
      e.at = at; e.gnt = g; e.cnt = c; e.dn = d; e.busy = b; e.tot = tot;
      exp_q.push_back(e);
   endtask

   task automatic exp_idle(input int at, input int tot);
      exp_state(at, 4'b0000, 4'd0, 4'b0000, 1'b0, tot);
   endtask

   // Interval granted at edge k to requester w with length L, request held throughout.
   task automatic push_interval(input int k, input int w, input int L);
      done_t d;
      logic [3:0] oh;
      oh = 4'b0001 << w;
      for (int j = 0; j < L; j++) exp_state(k + j, oh, 4'(L - j), 4'b0000, 1'b1, -1);
      exp_state(k + L, oh, 4'd0, oh, 1'b1, -1);
      exp_idle(k + L + 1, -1);
      d.at = k + L; d.vec = oh;
      done_q.push_back(d);
   endtask

   task automatic go_to(input int n);
      while (edge_n < n) @(negedge clock);
   endtask

   always @(negedge clock) begin
      exp_t  e;
      done_t d;
      while (exp_q.size() > 0 && exp_q[0].at <= edge_n) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (e.at != edge_n || gnt !== e.gnt || count !== e.cnt || done !== e.dn || busy !== e.busy) begin
            n_err++;
            $display("FAIL state@%0d (now %0d): got gnt=%b cnt=%0d done=%b busy=%b, want gnt=%b cnt=%0d done=%b busy=%b",
                     e.at, edge_n, gnt, count, done, busy, e.gnt, e.cnt, e.dn, e.busy);
         end
`ifdef SHARED_TIMER_STATS_EN
         if (e.tot >= 0) begin
            n_cmp++;
            if (done_total !== 8'(e.tot)) begin
               n_err++;
               $display("FAIL done_total@%0d: got %0d, want %0d", edge_n, done_total, e.tot);
            end
         end
`endif
      end
      if (done !== 4'b0000) begin
         n_cmp++;
         if (done_q.size() == 0) begin
            n_err++;
            $display("FAIL done_pulse@%0d: got unexpected done=%b, want none", edge_n, done);
         end else begin
            d = done_q.pop_front();
            if (d.at != edge_n || d.vec !== done) begin
               n_err++;
               $display("FAIL done_pulse@%0d: got done=%b, want done=%b at edge %0d", edge_n, done, d.vec, d.at);
            end
         end
      end
      if (fin && !mon_done) begin
         n_cmp++;
         if (exp_q.size() != 0 || done_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d state / %0d done expectations unconsumed, want 0 / 0",
                     exp_q.size(), done_q.size());
         end
         mon_done = 1;
      end
   end

   initial begin
      int k;
      reset  = 1;
      req    = 4'b1111;
      len_in = 16'h1111;
      @(negedge clock);
      // Reset dominates a full request vector.
      exp_idle(2, 0);
      exp_idle(3, 0);
      go_to(3);
      reset = 0;
      // All lengths 1, all requesting: grants rotate 0,1,2,3,0.
      k = 4;
      for (int i = 0; i < 5; i++) begin
         push_interval(k, i % 4, 1);
         k += 3;
      end
      go_to(18);
      req = 4'b0000;
      exp_idle(19, -1);

      // Length 3 for requester 2, held; length change mid-interval applies only to the re-grant.
      go_to(20);
      len_in[11:8] = 4'd3;
      req = 4'b0100;
      push_interval(21, 2, 3);
      go_to(22);
      len_in[11:8] = 4'd5;
      push_interval(26, 2, 5);
      go_to(32);
      req = 4'b0000;
      exp_idle(33, -1);

      // Zero length goes straight to DONE; dropping req while in DONE does not suppress it.
      go_to(34);
      len_in[7:4] = 4'd0;
      req = 4'b0010;
      push_interval(35, 1, 0);
      go_to(35);
      req = 4'b0000;
      exp_idle(37, -1);

      // Abort requester 3 at count 5; ptr wraps to 0 so requester 0 beats 1.
      go_to(38);
      len_in[15:12] = 4'd9;
      len_in[3:0]   = 4'd1;
      req = 4'b1011;
      for (int j = 0; j < 5; j++) exp_state(39 + j, 4'b1000, 4'(9 - j), 4'b0000, 1'b1, -1);
      go_to(43);
      req = 4'b0011;
      exp_idle(44, -1);
      push_interval(45, 0, 1);
      go_to(46);
      req = 4'b0000;
      exp_idle(48, 9);

`ifdef SHARED_TIMER_STATS_EN
      go_to(50);
      len_in[3:0] = 4'd0;
      req = 4'b0001;
      k = 51;
      for (int n = 0; n < 300; n++) begin
         push_interval(k, 0, 0);
         k += 2;
      end
      go_to(650);
      req = 4'b0000;
      exp_idle(651, 255);
      go_to(652);
      reset = 1;
      exp_idle(653, 0);
      go_to(653);
      reset = 0;
      go_to(655);
`else
      go_to(50);
`endif
      fin = 1;
      for (int t = 0; t < 10 && !mon_done; t++) @(negedge clock);
      if (!mon_done) begin
         $display("FAIL monitor_end: monitor did not complete, compared=%0d", n_cmp);
         $fatal(1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
